// File: rtl/ep2_extract_pkg.sv
// ep2_extract_pkg: shared types and helpers for the EP2 header extractor.
package ep2_extract_pkg;
  typedef enum logic [1:0] {HDR, BODY, FLUSH} state_t;
  localparam int TUSER_SHORT = 0;
  localparam int TUSER_EMPTY = 1;
  localparam int MAX_KEEP = 128;
  function automatic logic [MAX_KEEP-1:0] keep_mask(input int n);
    keep_mask = '0;
    for (int i = 0; i < MAX_KEEP; i++) keep_mask[i] = i < n;
  endfunction
endpackage

// File: rtl/axis_register.sv
// axis_register: full-throughput AXI-stream skid register, one cycle latency.
module axis_register #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready
);
  logic [W-1:0] skid;
  logic         skid_valid;
  assign s_ready = !skid_valid;
  always_ff @(posedge clk) begin
    if (rst) begin
      m_data <= '0;
      m_valid <= 1'b0;
      skid <= '0;
      skid_valid <= 1'b0;
    end else if (m_ready || !m_valid) begin
      m_valid <= skid_valid || s_valid;
      m_data <= skid_valid ? skid : s_data;
      skid_valid <= 1'b0;
    end else if (s_valid && s_ready) begin
      skid <= s_data;
      skid_valid <= 1'b1;
    end
  end
endmodule

// File: rtl/extract_hdr_stream.sv
// extract_hdr_stream: strips a multi-beat header struct and realigns the payload to lane 0.
// Define EXTRACT_SHORT_ERR_EN to flag short packets in tuser[0] instead of dropping them.
module extract_hdr_stream import ep2_extract_pkg::*; #(
  parameter int BUF_DATA_WIDTH = 256,
  parameter int BUF_KEEP_WIDTH = BUF_DATA_WIDTH/8,
  parameter int STRUCT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [BUF_DATA_WIDTH-1:0] s_inbuf_axis_tdata,
  input  logic [BUF_KEEP_WIDTH-1:0] s_inbuf_axis_tkeep,
  input  logic                      s_inbuf_axis_tvalid,
  output logic                      s_inbuf_axis_tready,
  input  logic                      s_inbuf_axis_tlast,
  output logic [STRUCT_WIDTH-1:0]   m_extracted_axis_tdata,
  output logic                      m_extracted_axis_tvalid,
  input  logic                      m_extracted_axis_tready,
  output logic [1:0]                m_extracted_axis_tuser,
  output logic [BUF_DATA_WIDTH-1:0] m_outbuf_axis_tdata,
  output logic [BUF_KEEP_WIDTH-1:0] m_outbuf_axis_tkeep,
  output logic                      m_outbuf_axis_tvalid,
  input  logic                      m_outbuf_axis_tready,
  output logic                      m_outbuf_axis_tlast
);
  localparam int DW = BUF_DATA_WIDTH;
  localparam int KW = BUF_KEEP_WIDTH;
  localparam int SB = STRUCT_WIDTH/8;
  localparam int HB = (SB + KW - 1)/KW;
  localparam int OFS = SB % KW;
  localparam int RB = KW - OFS;
  localparam int NEED = OFS == 0 ? KW : OFS;
  localparam int CW = HB > 1 ? $clog2(HB) : 1;
  localparam int BCW = $clog2(KW + 1);
`ifdef EXTRACT_SHORT_ERR_EN
  localparam bit SHORT_ERR = 1'b1;
`else
  localparam bit SHORT_ERR = 1'b0;
`endif
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [HB*DW-1:0] acc, acc_n;
  logic [DW-1:0] res, res_n, d, pl_data;
  logic [BCW-1:0] res_cnt, res_cnt_n;
  logic [KW-1:0] pl_keep;
  logic [1:0] st_user;
  logic [DW+KW:0] pl_q;
  logic [STRUCT_WIDTH+1:0] st_q;
  int kcnt, pl_cnt;
  logic last_hdr, short_pkt, done_hdr, push_st, tail, fire;
  logic pl_valid, pl_ready, pl_last, st_valid, st_ready;
  always_comb begin
    kcnt = 0;
    d = '0;
    for (int i = 0; i < KW; i++) begin
      kcnt = kcnt + int'(s_inbuf_axis_tkeep[i]);
      d[i*8 +: 8] = s_inbuf_axis_tdata[i*8 +: 8] & {8{s_inbuf_axis_tkeep[i]}};
    end
    last_hdr = cnt == CW'(HB - 1);
    short_pkt = s_inbuf_axis_tlast && (!last_hdr || kcnt < NEED);
    done_hdr = last_hdr && !short_pkt;
    push_st = done_hdr || (SHORT_ERR && short_pkt);
    // beat holds bytes past lane OFS-1 that spill into the residual
    tail = OFS != 0 && kcnt > OFS;
  end
  assign s_inbuf_axis_tready = !rst && (state == HDR ? (!push_st || st_ready) :
                                        state == BODY ? pl_ready : 1'b0);
  assign fire = s_inbuf_axis_tvalid && s_inbuf_axis_tready;
  always_ff @(posedge clk) begin
    if (rst) state <= HDR;
    else state <= state_n;
  end
  always_comb begin
    state_n = state == HDR  ? (fire && done_hdr ? (!s_inbuf_axis_tlast ? BODY : tail ? FLUSH : HDR) : HDR) :
              state == BODY ? (fire && s_inbuf_axis_tlast ? (tail ? FLUSH : HDR) : BODY) :
                              (pl_ready ? HDR : FLUSH);
  end
  always_comb begin
    acc_n = cnt == '0 ? '0 : acc;
    acc_n[cnt*DW +: DW] = d;
    cnt_n = (short_pkt || done_hdr) ? '0 : cnt + 1'b1;
    res_n = d >> (OFS*8);
    res_cnt_n = tail ? BCW'(kcnt - OFS) : '0;
    st_valid = fire && state == HDR && push_st;
    st_user = '0;
    st_user[TUSER_SHORT] = SHORT_ERR && short_pkt;
    st_user[TUSER_EMPTY] = done_hdr && s_inbuf_axis_tlast && !tail;
    pl_valid = state == FLUSH || (fire && state == BODY);
    pl_data = state == FLUSH ? res : OFS == 0 ? d : res | (d << ((RB % KW)*8));
    pl_cnt = state == FLUSH ? int'(res_cnt) : OFS == 0 ? kcnt : RB + (kcnt < OFS ? kcnt : OFS);
    pl_keep = KW'(keep_mask(pl_cnt));
    pl_last = state == FLUSH || (s_inbuf_axis_tlast && !tail);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      acc <= '0;
      res <= '0;
      res_cnt <= '0;
    end else if (fire) begin
      if (state == HDR) begin
        cnt <= cnt_n;
        acc <= acc_n;
      end
      res <= res_n;
      res_cnt <= res_cnt_n;
    end
  end
  axis_register #(.W(STRUCT_WIDTH + 2)) u_struct_reg (
    .clk(clk), .rst(rst),
    .s_data({st_user, acc_n[STRUCT_WIDTH-1:0]}), .s_valid(st_valid), .s_ready(st_ready),
    .m_data(st_q), .m_valid(m_extracted_axis_tvalid), .m_ready(m_extracted_axis_tready)
  );
  axis_register #(.W(DW + KW + 1)) u_payload_reg (
    .clk(clk), .rst(rst),
    .s_data({pl_last, pl_keep, pl_data}), .s_valid(pl_valid), .s_ready(pl_ready),
    .m_data(pl_q), .m_valid(m_outbuf_axis_tvalid), .m_ready(m_outbuf_axis_tready)
  );
  assign {m_extracted_axis_tuser, m_extracted_axis_tdata} = st_q;
  assign {m_outbuf_axis_tlast, m_outbuf_axis_tkeep, m_outbuf_axis_tdata} = pl_q;
endmodule

// File: tb/tb_extract_hdr_stream.sv
// tb_extract_hdr_stream: table-driven and scoreboard bench for extract_hdr_stream (64-bit bus, 80-bit struct).
module tb_extract_hdr_stream;
  localparam int DW = 64;
  localparam int KW = 8;
  localparam int SW = 80;
  localparam int SB = 10;
  localparam logic [SW-1:0] FULL = 80'h09080706050403020100;
`ifdef EXTRACT_SHORT_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [DW-1:0] in_data = '0;
  logic [KW-1:0] in_keep = '0;
  logic in_valid = 1'b0, in_last = 1'b0, in_ready;
  logic [SW-1:0] st_data;
  logic [1:0] st_user;
  logic st_valid, st_ready = 1'b1;
  logic [DW-1:0] pl_data;
  logic [KW-1:0] pl_keep;
  logic pl_valid, pl_last, pl_ready = 1'b1;
  extract_hdr_stream #(.BUF_DATA_WIDTH(DW), .BUF_KEEP_WIDTH(KW), .STRUCT_WIDTH(SW)) dut (
    .clk(clk), .rst(rst),
    .s_inbuf_axis_tdata(in_data), .s_inbuf_axis_tkeep(in_keep), .s_inbuf_axis_tvalid(in_valid),
    .s_inbuf_axis_tready(in_ready), .s_inbuf_axis_tlast(in_last),
    .m_extracted_axis_tdata(st_data), .m_extracted_axis_tvalid(st_valid),
    .m_extracted_axis_tready(st_ready), .m_extracted_axis_tuser(st_user),
    .m_outbuf_axis_tdata(pl_data), .m_outbuf_axis_tkeep(pl_keep), .m_outbuf_axis_tvalid(pl_valid),
    .m_outbuf_axis_tready(pl_ready), .m_outbuf_axis_tlast(pl_last)
  );
  typedef struct {logic [SW-1:0] d; logic [1:0] u;} st_t;
  typedef struct {logic [DW-1:0] d; logic [KW-1:0] k; logic l;} pl_t;
  typedef struct {int len; bit has_st; logic [SW-1:0] st; logic [1:0] u; int beats; logic [KW-1:0] lk;} vec_t;
  st_t st_q[$];
  pl_t pl_q[$];
  st_t se;
  pl_t pe;
  vec_t vt[10];
  logic [7:0] pkt [256];
  int checks = 0, failures = 0, n_pl = 0, n_st = 0, stall = 0;
  logic [KW-1:0] last_keep = '0;
  bit rand_ready = 1'b0;

  function automatic logic [DW-1:0] kmask(input logic [KW-1:0] k);
    logic [DW-1:0] m;
    for (int i = 0; i < KW; i++) m[i*8 +: 8] = {8{k[i]}};
    return m;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_st(input int len);
    st_t e;
    e.d = '0;
    for (int b = 0; b < SB; b++) if (b < len) e.d[b*8 +: 8] = pkt[b];
    e.u = len >= SB ? {len == SB, 1'b0} : 2'b01;
    if (len >= SB || ERR) st_q.push_back(e);
  endtask

  task automatic push_pl(input int len);
    pl_t e;
    for (int o = SB; o < len; o += KW) begin
      e.d = '0;
      e.k = '0;
      for (int j = 0; j < KW; j++) if (o + j < len) begin
        e.d[j*8 +: 8] = pkt[o+j];
        e.k[j] = 1'b1;
      end
      e.l = o + KW >= len;
      pl_q.push_back(e);
    end
  endtask

  task automatic wait_accept();
    int t;
    for (t = 0; t < 1000; t++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (t == 1000) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got tready=0 for %0d cycles expected accept", t);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input int o, input int len);
    for (int j = 0; j < KW; j++) begin
      in_data[j*8 +: 8] = o + j < len ? pkt[o+j] : 8'hEE;
      in_keep[j] = o + j < len;
    end
    in_last = o + KW >= len;
    in_valid = 1'b1;
  endtask

  task automatic send(input int len, input bit gaps);
    for (int o = 0; o < len; o += KW) begin
      if (gaps) while ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      drive_beat(o, len);
      wait_accept();
    end
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic drain();
    int t;
    for (t = 0; t < 500 && (st_q.size() != 0 || pl_q.size() != 0); t++) @(negedge clk);
    if (t >= 500) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d/%0d pending expected 0/0", st_q.size(), pl_q.size());
    end
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(negedge clk);
    if (!rst && st_valid && st_ready) begin
      n_st++;
      if (st_q.size() == 0) check("st_unexpected", st_data, 0);
      else begin
        se = st_q.pop_front();
        check("st_data", st_data, se.d);
        check("st_user", st_user, se.u);
      end
    end
    if (!rst && pl_valid && pl_ready) begin
      n_pl++;
      last_keep = pl_keep;
      if (pl_q.size() == 0) check("pl_unexpected", pl_keep, 0);
      else begin
        pe = pl_q.pop_front();
        check("pl_data", pl_data & kmask(pl_keep), pe.d);
        check("pl_keep", pl_keep, pe.k);
        check("pl_last", pl_last, pe.l);
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) begin
      pl_ready = $urandom_range(0, 3) != 0;
      st_ready = $urandom_range(0, 3) != 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    vt[0] = '{20, 1'b1, FULL, 2'b00, 2, 8'h03};
    vt[1] = '{24, 1'b1, FULL, 2'b00, 2, 8'h3F};
    vt[2] = '{10, 1'b1, FULL, 2'b10, 0, 8'h00};
    vt[3] = '{6, ERR, 80'h050403020100, 2'b01, 0, 8'h00};
    vt[4] = '{16, 1'b1, FULL, 2'b00, 1, 8'h3F};
    vt[5] = '{12, 1'b1, FULL, 2'b00, 1, 8'h03};
    vt[6] = '{18, 1'b1, FULL, 2'b00, 1, 8'hFF};
    vt[7] = '{9, ERR, 80'h080706050403020100, 2'b01, 0, 8'h00};
    vt[8] = '{8, ERR, 80'h0706050403020100, 2'b01, 0, 8'h00};
    vt[9] = '{33, 1'b1, FULL, 2'b00, 3, 8'h7F};
    repeat (3) @(negedge clk);
    check("rst_tready", in_ready, 0);
    check("rst_st_valid", st_valid, 0);
    check("rst_pl_valid", pl_valid, 0);
    check("rst_st_data", st_data, 0);
    check("rst_st_user", st_user, 0);
    check("rst_pl_data", pl_data, 0);
    check("rst_pl_keep", pl_keep, 0);
    check("rst_pl_last", pl_last, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int b = 0; b < 256; b++) pkt[b] = 8'(b);
    for (int v = 0; v < 10; v++) begin
      n_pl = 0;
      n_st = 0;
      if (vt[v].has_st) st_q.push_back('{vt[v].st, vt[v].u});
      push_pl(vt[v].len);
      send(vt[v].len, 1'b0);
      drain();
      check($sformatf("vec%0d_n_st", v), n_st, vt[v].has_st);
      check($sformatf("vec%0d_n_pl", v), n_pl, vt[v].beats);
      if (vt[v].beats > 0) check($sformatf("vec%0d_last_keep", v), last_keep, vt[v].lk);
    end
    // payload backpressure mid-packet must stall the input without loss
    push_st(33);
    push_pl(33);
    fork
      send(33, 1'b0);
      begin
        repeat (2) @(posedge clk);
        #1;
        pl_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          if (in_valid && !in_ready) stall++;
        end
        @(posedge clk);
        #1;
        pl_ready = 1'b1;
      end
    join
    drain();
    check("bp_input_stalled", stall > 0, 1);
    // reset in the middle of a 20-byte packet
    st_ready = 1'b0;
    pl_ready = 1'b0;
    drive_beat(0, 20);
    wait_accept();
    drive_beat(8, 20);
    wait_accept();
    in_valid = 1'b0;
    in_last = 1'b0;
    @(negedge clk);
    check("pre_rst_st_valid", st_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_st_valid", st_valid, 0);
    check("mid_rst_pl_valid", pl_valid, 0);
    check("mid_rst_tready", in_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    st_ready = 1'b1;
    pl_ready = 1'b1;
    n_pl = 0;
    push_st(20);
    push_pl(20);
    send(20, 1'b0);
    drain();
    check("post_rst_n_pl", n_pl, 2);
    // random packets with random downstream readiness
    rand_ready = 1'b1;
    for (int p = 0; p < 100; p++) begin
      int len;
      len = $urandom_range(1, 40);
      for (int b = 0; b < len; b++) pkt[b] = 8'($urandom);
      push_st(len);
      push_pl(len);
      send(len, 1'b1);
    end
    drain();
    rand_ready = 1'b0;
    st_ready = 1'b1;
    pl_ready = 1'b1;
    check("rand_st_left", st_q.size(), 0);
    check("rand_pl_left", pl_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/extract_hdr_stream.md
# extract_hdr_stream

Parametrised header extractor for the EP2 AXI-stream datapath. It strips a fixed-size struct of `STRUCT_WIDTH` bits from the head of every packet and emits it on a dedicated struct stream. The remaining payload is forwarded re-aligned to lane 0. It generalises the single-beat extractor:

- the struct may span several input beats;
- the payload carries correct tkeep/tlast, including the trailing flush beat;
- short packets are detected.

## Interface
- `BUF_DATA_WIDTH`, 256: payload bus width in bits; must be a multiple of 8.
- `BUF_KEEP_WIDTH`, `BUF_DATA_WIDTH/8`: tkeep width.
- `STRUCT_WIDTH`, 16: extracted struct width in bits; a multiple of 8, between 8 and `4*BUF_DATA_WIDTH`.
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `s_inbuf_axis_tdata`/`tkeep`/`tvalid`/`tready`/`tlast`, in/in/in/out/in, `BUF_DATA_WIDTH`/`BUF_KEEP_WIDTH`/1/1/1: input packet stream.
- `m_extracted_axis_tdata`/`tvalid`/`tready`, out/out/in, `STRUCT_WIDTH`/1/1: struct; byte 0 of the packet sits in bits [7:0].
- `m_extracted_axis_tuser`, out, 2: bit0 short packet, bit1 empty payload.
- `m_outbuf_axis_tdata`/`tkeep`/`tvalid`/`tready`/`tlast`, out/out/out/in/out, `BUF_DATA_WIDTH`/`BUF_KEEP_WIDTH`/1/1/1: payload stream.

## Operation
- Derived constants:
  - SB = STRUCT_WIDTH/8
  - HB = ceil(SB/BUF_KEEP_WIDTH), the number of header beats
  - OFS = SB mod BUF_KEEP_WIDTH, the payload byte offset
- Input contract: tkeep is contiguous from lane 0, and all-ones on every non-last beat.
- States:
  - **HDR**: counts header beats (0..HB-1) and accumulates bytes into the struct register.
  - **BODY**: forwards payload beats.
  - **FLUSH**: emits the residual payload bytes after tlast.
- In HDR, the beat carrying byte SB-1:
  - pushes the struct to the struct output;
  - loads bytes OFS..KEEP-1 of that beat into the residual register.
- Transition out of that header beat:
  - if it is also tlast: payload residual non-empty → FLUSH; otherwise → HDR with tuser[1]=1.
  - if it is not tlast → BODY.
- In BODY, each accepted beat:
  - emits {beat[OFS-1:0], residual};
  - moves beat bytes OFS.. into the residual.
- On tlast in BODY:
  - if the combined bytes fit in one output beat, they are emitted with tlast → HDR;
  - otherwise → FLUSH, which emits the residual with tlast → HDR.
- OFS==0: no residual is kept and payload beats pass through unshifted; FLUSH is never entered.
- Output tkeep is the compacted byte count as a contiguous mask.
- Short packet (tlast before byte SB-1):
  - the struct is emitted zero-filled above the received bytes (see Configuration for the error flag);
  - no payload is emitted;
  - state → HDR.
- The struct is pushed before the first payload beat of the same packet. The two outputs are otherwise independent.

## Timing
- Reset values: all `m_*_tvalid` = 0, tdata/tkeep/tuser/tlast = 0, `s_inbuf_axis_tready` = 0 during rst. State = HDR, beat counter = 0, residual cleared.
- Both outputs are full-throughput skid registers (REG_TYPE 2). Latency is 1 cycle from the accepting input beat to output valid.
- FLUSH adds one output cycle after tlast. While in FLUSH, tready = 0.
- `s_inbuf_axis_tready` is deasserted when:
  - in HDR on the completing beat, the struct register is full;
  - the payload register cannot accept an emitted beat.
- Back-to-back packets: the first header beat of the next packet may be accepted in the cycle after the FLUSH beat is accepted downstream.
- Reset mid-packet:
  - partial struct and residual are discarded;
  - outputs are invalidated on the next edge;
  - downstream must tolerate the truncated packet.

## Configuration
- `EXTRACT_SHORT_ERR_EN`
  - defined: tuser[0] flags short packets.
  - undefined: tuser[0] is tied 0, and short packets are silently dropped, emitting neither a struct nor a payload.

## Structure
- Package `ep2_extract_pkg`:
  - state enum (HDR/BODY/FLUSH);
  - tuser bit indices;
  - function computing a contiguous keep mask from a byte count.
- Sub-module `axis_register` is instantiated twice, once per output. Shift/realign logic stays inline.

## Test plan
Default bench configuration: `BUF_DATA_WIDTH`=64, `STRUCT_WIDTH`=80, so SB=10, HB=2, OFS=2. Byte value = byte index.
- **20-byte packet** (keep FF, FF, 0F): struct 0x09..00, tuser 0. Payload: beat bytes 10–17 keep FF; beat bytes 18–19 keep 03 with tlast; no FLUSH beat.
- **24-byte packet** (FF, FF, FF): payload beat 10–17 keep FF, then a FLUSH beat 18–23 keep 3F with tlast.
- **10-byte packet** (FF, 03): struct valid, tuser=2'b10, no payload beats.
- **6-byte packet** (keep 3F) with the macro defined: struct 0x00000000050403020100, tuser=2'b01, no payload. Without the macro: no outputs at all.
- **Backpressure**: hold `m_outbuf` tready low for 5 cycles mid-packet. Input stalls, and no data is lost or duplicated across 100 random packets checked against a scoreboard.
- **Reset mid-packet**: assert rst in cycle 2 of the 20-byte packet. All outputs go invalid. The next packet extracts correctly.
